// File: rtl/fc_pkg.sv
// ============================================================================
// Module  : fc_pkg
// Brief   : Shared types and constants for the fully-connected layer sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

  localparam int FC_DATA_WIDTH = 32;
  localparam int W_RD_LATENCY  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fc_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_layer_ctrl_if.sv
// ============================================================================
// Module  : fc_layer_ctrl_if
// Brief   : Weight-memory read port and broadcast PE operand bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fc_layer_ctrl_if
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int IDX_W      = 7
);

  logic                  w_rd_en;
  logic [IDX_W-1:0]      w_addr;
  logic [DATA_WIDTH-1:0] pe_a;
  logic                  pe_valid;
  logic                  pe_clear;

  modport master (
    output w_rd_en, w_addr, pe_a, pe_valid, pe_clear
  );

  modport slave (
    input w_rd_en, w_addr, pe_a, pe_valid, pe_clear
  );

endinterface

`default_nettype wire

// File: rtl/fc_input_sel.sv
// ============================================================================
// Module  : fc_input_sel
// Brief   : Registered input-word mux; operand lands one cycle after selection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_input_sel
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = FC_DATA_WIDTH,
  parameter int INPUT_NODES = 100,
  parameter int IDX_W       = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1
) (
  input  wire logic                              clk,
  input  wire logic                              reset,
  input  wire logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc,
  input  wire logic [IDX_W-1:0]                  idx,
  input  wire logic                              en,
  output logic      [DATA_WIDTH-1:0]             pe_a,
  output logic                                   pe_valid
);

  logic [DATA_WIDTH-1:0] w_words [INPUT_NODES];

  for (genvar gi = 0; gi < INPUT_NODES; gi++) begin : g_words
    assign w_words[gi] = input_fc[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // pe_a keeps its last operand whenever no read is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_a     <= '0;
      pe_valid <= 1'b0;
    end else begin
      pe_valid <= en;
      if (en) begin
        pe_a <= w_words[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fc_layer_ctrl.sv
// ============================================================================
// Module  : fc_layer_ctrl
// Brief   : Start/stall/done sequencer feeding inputs and weight reads to PEs.
//           Optional FC_LAYER_CTRL_CYCLE_CNT_EN adds a 32-bit cycle_count port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = FC_DATA_WIDTH,
  parameter int INPUT_NODES = 100,
  parameter int PE_LATENCY  = 4,
  parameter int IDX_W       = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1
) (
  input  wire logic                              clk,
  input  wire logic                              reset,
  input  wire logic                              start,
  input  wire logic                              stall,
  input  wire logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc,
  fc_layer_ctrl_if.master                        pe_bus,
  output logic                                   busy,
  output logic                                   done
`ifdef FC_LAYER_CTRL_CYCLE_CNT_EN
  ,
  output logic      [31:0]                       cycle_count
`endif
);

  localparam int               DRAIN_CYCLES = PE_LATENCY + W_RD_LATENCY;
  localparam int               DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] C_DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0]   C_LAST       = IDX_W'(INPUT_NODES - 1);

  fc_state_t           r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_w_addr;
  logic                r_w_rd_en;
  logic                r_pe_clear;
  logic                r_busy;
  logic                r_done;
  logic [DRAIN_W-1:0]  r_drain;
  logic                r_feed_end;
  logic [DATA_WIDTH-1:0] w_pe_a;
  logic                w_pe_valid;

  // Read decisions are registered: the read seen in cycle t was chosen from stall in t-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_w_addr   <= '0;
      r_w_rd_en  <= 1'b0;
      r_pe_clear <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drain    <= '0;
      r_feed_end <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= CLEAR;
            r_pe_clear <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        CLEAR: begin
          r_pe_clear <= 1'b0;
          r_idx      <= '0;
          r_feed_end <= 1'b0;
          r_state    <= FEED;
          if (!stall) begin
            r_w_rd_en <= 1'b1;
            r_w_addr  <= '0;
            if (C_LAST == '0) begin
              r_feed_end <= 1'b1;
            end else begin
              r_idx <= IDX_W'(1);
            end
          end
        end
        FEED: begin
          if (r_feed_end) begin
            r_w_rd_en <= 1'b0;
            r_drain   <= C_DRAIN_INIT;
            r_state   <= DRAIN;
          end else if (stall) begin
            r_w_rd_en <= 1'b0;
          end else begin
            r_w_rd_en <= 1'b1;
            r_w_addr  <= r_idx;
            if (r_idx == C_LAST) begin
              r_feed_end <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (r_drain == '0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_drain <= r_drain - DRAIN_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fc_input_sel #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INPUT_NODES (INPUT_NODES),
    .IDX_W       (IDX_W)
  ) u_input_sel (
    .clk      (clk),
    .reset    (reset),
    .input_fc (input_fc),
    .idx      (r_w_addr),
    .en       (r_w_rd_en),
    .pe_a     (w_pe_a),
    .pe_valid (w_pe_valid)
  );

  assign pe_bus.w_rd_en  = r_w_rd_en;
  assign pe_bus.w_addr   = r_w_addr;
  assign pe_bus.pe_a     = w_pe_a;
  assign pe_bus.pe_valid = w_pe_valid;
  assign pe_bus.pe_clear = r_pe_clear;
  assign busy            = r_busy;
  assign done            = r_done;

`ifdef FC_LAYER_CTRL_CYCLE_CNT_EN
  logic [31:0] r_cnt;

  // The DONE cycle itself is included in the published count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      cycle_count <= '0;
    end else begin
      case (r_state)
        CLEAR:       r_cnt       <= '0;
        FEED, DRAIN: r_cnt       <= sat_inc32(r_cnt);
        DONE:        cycle_count <= sat_inc32(r_cnt);
        default:     r_cnt       <= r_cnt;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_ctrl.sv
// ============================================================================
// Module  : tb_fc_layer_ctrl
// Brief   : Self-checking bench: event-timeline model of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_layer_ctrl;
  import fc_pkg::*;

  localparam int N_A  = 4;
  localparam int PE_A = 3;

  logic clk = 1'b0;
  logic reset, start_a, start_b, stall;
  logic [32*N_A-1:0] in_a;
  logic [31:0]       in_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [31:0] wd [N_A];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fc_layer_ctrl_if #(.DATA_WIDTH(32), .IDX_W(2)) bus_a ();
  fc_layer_ctrl_if #(.DATA_WIDTH(32), .IDX_W(1)) bus_b ();

`ifdef FC_LAYER_CTRL_CYCLE_CNT_EN
  logic [31:0] cc_a, cc_b;
`endif

  fc_layer_ctrl #(.DATA_WIDTH(32), .INPUT_NODES(N_A), .PE_LATENCY(PE_A), .IDX_W(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stall(stall), .input_fc(in_a),
    .pe_bus(bus_a), .busy(busy_a), .done(done_a)
`ifdef FC_LAYER_CTRL_CYCLE_CNT_EN
    , .cycle_count(cc_a)
`endif
  );

  fc_layer_ctrl #(.DATA_WIDTH(32), .INPUT_NODES(1), .PE_LATENCY(1), .IDX_W(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stall(stall), .input_fc(in_b),
    .pe_bus(bus_b), .busy(busy_b), .done(done_b)
`ifdef FC_LAYER_CTRL_CYCLE_CNT_EN
    , .cycle_count(cc_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_words(input bit fixed);
    for (int i = 0; i < N_A; i++) begin
      wd[i] = fixed ? (32'h3F80_0000 + 32'(i) * 32'h0080_0000) : $urandom;
      if (fixed && i > 0) wd[i] = 32'h4000_0000 + 32'(i - 1) * 32'h0040_0000;
      in_a[32*i +: 32] = wd[i];
    end
  endtask

  // Model: a read may land in cycle c (c >= 2) only if stall was low in c-1;
  // done follows the last read after one alignment cycle plus the PE drain.
  task automatic run_a(input int mode, input int pct, input bit hold, input bit fixed);
    int  rd_cyc [N_A];
    bit  pat [64];
    int  k, c, done_c, ak, vk;
    bit  e_rd, e_pv, seen;
    set_words(fixed);
    for (int i = 0; i < 64; i++)
      pat[i] = (mode == 1) ? (i == 2 || i == 3)
                           : (i >= 2 && i < 40 && $urandom_range(99) < pct);
    k = 0;
    c = 2;
    while (k < N_A) begin
      if (!pat[c-1]) begin
        rd_cyc[k] = c;
        k++;
      end
      c++;
    end
    done_c = rd_cyc[N_A-1] + PE_A + 2;

    @(posedge clk); #1 start_a = 1'b1; stall = pat[0];
    @(negedge clk);
    check("idle_busy", 64'(busy_a), 64'd0);
    for (int cy = 1; cy <= done_c + 1; cy++) begin
      @(posedge clk); #1 start_a = hold; stall = pat[cy];
      @(negedge clk);
      e_rd = 1'b0; e_pv = 1'b0; ak = 0; vk = 0;
      for (int j = 0; j < N_A; j++) begin
        if (rd_cyc[j] == cy)     begin e_rd = 1'b1; ak = j; end
        if (rd_cyc[j] + 1 == cy) begin e_pv = 1'b1; vk = j; end
      end
      check($sformatf("pe_clear@%0d", cy), 64'(bus_a.pe_clear), 64'(cy == 1));
      check($sformatf("busy@%0d", cy), 64'(busy_a), 64'(cy <= done_c));
      check($sformatf("done@%0d", cy), 64'(done_a), 64'(cy == done_c));
      check($sformatf("w_rd_en@%0d", cy), 64'(bus_a.w_rd_en), 64'(e_rd));
      check($sformatf("pe_valid@%0d", cy), 64'(bus_a.pe_valid), 64'(e_pv));
      if (e_rd) check($sformatf("w_addr@%0d", cy), 64'(bus_a.w_addr), 64'(ak));
      if (e_pv) check($sformatf("pe_a@%0d", cy), 64'(bus_a.pe_a), 64'(wd[vk]));
      if (cy > rd_cyc[N_A-1] + 1) check($sformatf("pe_a_hold@%0d", cy), 64'(bus_a.pe_a), 64'(wd[N_A-1]));
`ifdef FC_LAYER_CTRL_CYCLE_CNT_EN
      if (cy == done_c + 1) check("cycle_count", 64'(cc_a), 64'(done_c - 1));
`endif
    end
    if (hold) begin
      @(posedge clk); #1 stall = 1'b0;
      @(negedge clk);
      check("hold_reclear", 64'(bus_a.pe_clear), 64'd1);
      check("hold_rebusy", 64'(busy_a), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk);
        seen = done_a;
      end
      check("hold_second_done", 64'(seen), 64'd1);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    stall   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; stall = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_rd_en", 64'(bus_a.w_rd_en), 64'd0);
    check("rst_addr", 64'(bus_a.w_addr), 64'd0);
    check("rst_pe_a", 64'(bus_a.pe_a), 64'd0);
    check("rst_valid", 64'(bus_a.pe_valid), 64'd0);
    check("rst_clear", 64'(bus_a.pe_clear), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_a(0, 0, 1'b0, 1'b1);
    run_a(1, 0, 1'b0, 1'b1);
    run_a(0, 0, 1'b1, 1'b1);

    // Abort mid-FEED: outputs drop in the same cycle and no done follows.
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_rd_en", 64'(bus_a.w_rd_en), 64'd0);
    check("abort_addr", 64'(bus_a.w_addr), 64'd0);
    check("abort_valid", 64'(bus_a.pe_valid), 64'd0);
    check("abort_pe_a", 64'(bus_a.pe_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_done", 64'(done_a), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet@%0d", i), 64'({busy_a, done_a}), 64'd0);
    end
    run_a(0, 0, 1'b0, 1'b1);

    // Single-input configuration
    in_b = $urandom;
    @(posedge clk); #1 start_b = 1'b1; stall = 1'b0;
    @(negedge clk);
    check("b_idle_busy", 64'(busy_b), 64'd0);
    for (int cy = 1; cy <= 7; cy++) begin
      @(posedge clk); #1 start_b = 1'b0;
      @(negedge clk);
      check($sformatf("b_clear@%0d", cy), 64'(bus_b.pe_clear), 64'(cy == 1));
      check($sformatf("b_rd_en@%0d", cy), 64'(bus_b.w_rd_en), 64'(cy == 2));
      check($sformatf("b_valid@%0d", cy), 64'(bus_b.pe_valid), 64'(cy == 3));
      check($sformatf("b_done@%0d", cy), 64'(done_b), 64'(cy == 5));
      check($sformatf("b_busy@%0d", cy), 64'(busy_b), 64'(cy <= 5));
      if (cy == 2) check("b_addr", 64'(bus_b.w_addr), 64'd0);
      if (cy == 3) check("b_pe_a", 64'(bus_b.pe_a), 64'(in_b));
    end

    for (int r = 0; r < 6; r++) run_a(0, 30, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
